c_top: RTL and testbench
========================

// Module: c_top
// PURPOSE
// - Frontend control stage C1: holds the fetch line pointer and drives a pair of cache-line counters (CLCs).
// - Each cycle it emits one even-bank and one odd-bank line address to fetch stage F1.
// - Handles redirects (resteers) from decode D1, the branch unit BR and the ROB.
// - Contains the return-address stack (RAS) fed by decode; the RAS top goes to F2 as a predicted target.
// PARAMETERS
// - XLEN       32  address width
// - CLC_WIDTH  28  cache-line counter width; XLEN-CLC_WIDTH = 4 offset bits (16 B line)
// - RAS_DEPTH  8   RAS entries (power of 2)
// - RESET_PC   0   fetch address after reset
// PORTS
// - clk                 in   1          clock
// - rst                 in   1          synchronous, active-low reset
// - stall_in            in   1          hold fetch pointer
// - resteer             in   1          pipeline flush marker; no effect on pointer by itself
// - resteer_target_D1   in   XLEN       D1 redirect target
// - resteer_taken_D1    in   1          D1 redirect request
// - resteer_target_BR   in   XLEN       mispredict target
// - resteer_taken_BR    in   1          mispredict request
// - resteer_target_ROB  in   XLEN       exception target
// - resteer_taken_ROB   in   1          exception request
// - ras_push            in   1          push ras_ret_addr
// - ras_pop             in   1          pop top entry
// - ras_ret_addr        in   XLEN       return address to push
// - ras_valid_in        in   1          qualifies ras_push
// - clc_even            out  CLC_WIDTH  even-bank line (bit0 = 0)
// - clc_odd             out  CLC_WIDTH  odd-bank line (bit0 = 1)
// - ras_data_out        out  XLEN       RAS top (0 when empty)
// - ras_valid_out       out  1          RAS non-empty
// BEHAVIOUR
// - State: line pointer L[CLC_WIDTH-1:0].
// - clc_even = L[0] ? L+1 : L; clc_odd = L[0] ? L : L+1.
//   - Both are combinational from the registered L; the +1 wraps modulo 2^CLC_WIDTH.
// - Next-L priority each posedge:
//   - rst==0 -> RESET_PC[XLEN-1:4]
//   - resteer_taken_ROB -> ROB target[XLEN-1:4]
//   - resteer_taken_BR -> BR target[XLEN-1:4]
//   - resteer_taken_D1 -> D1 target[XLEN-1:4]
//   - stall_in -> hold L
//   - otherwise -> L+2, wrapping
// - Redirects override stall_in.
// - Target offset bits [3:0] are discarded; intra-line offset is handled downstream.
// - Latency: a redirect sampled at edge N shows on clc_* after edge N (one cycle).
// - Reset values: L = RESET_PC>>4 (clc_even=0, clc_odd=1 for default); RAS empty; ras_data_out=0; ras_valid_out=0.
// - RAS: circular buffer with top pointer and occupancy count 0..RAS_DEPTH.
//   - Push (ras_push & ras_valid_in) only: write at top+1, top++, count saturates at DEPTH.
//     A push when full overwrites the oldest entry.
//   - Pop only: top--, count--. Pop when empty is a no-op.
//   - Push and pop together: replace the top entry in place; count unchanged (sets count=1 if empty).
//   - resteer_taken_ROB clears the RAS (count=0) and takes priority over push/pop that cycle.
//   - RAS ops are independent of stall_in.
//   - ras_data_out = mem[top] when count>0, else 0. ras_valid_out = (count!=0).
// - Reset asserted mid-operation: overrides every input on that edge.
// STRUCTURE
// - Shared package frontend_pkg: XLEN, CLC_WIDTH, LINE_OFFSET_BITS=4, RESET_PC, RAS_DEPTH.
// - One sub-module c_ras (RAS storage and pointers).
//   - Ports: clk, rst, push, pop, clear, din, dout, valid.
// - Pointer/redirect logic stays in c_top.
// TESTING
// - Reset, free-run:
//   - rst=0 then 1, no stall -> clc_even/odd = 0/1, then 2/3, then 4/5 on successive cycles.
// - Stall:
//   - stall_in=1 for 3 cycles at L=4 -> outputs hold 4/5; resume -> 6/7.
// - Redirect priority and odd alignment:
//   - All three taken in one cycle (ROB=0x1000, BR=0x2000, D1=0x3000) -> next 0x100/0x101.
//   - BR only, target 0x2014 -> L=0x201; outputs even=0x202, odd=0x201.
// - Redirect during stall:
//   - stall_in=1 with taken_BR target 0x40 -> next outputs 4/5.
// - Wrap:
//   - Redirect to 0xFFFFFFF0 -> even=0x0000000, odd=0xFFFFFFF.
//   - Next cycle L=1 -> even=2, odd=1.
// - RAS:
//   - Push A,B -> dout=B, valid=1.
//   - Push+pop with C -> dout=C.
//   - Pop twice -> empty: dout=0, valid=0.
//   - 9 pushes into depth 8 -> 8 pops return the last 8 pushed.
//   - taken_ROB clears -> valid=0.

Source files
------------

// File: rtl/frontend_pkg.sv
// Shared frontend parameters and helpers for the C1 control stage.
package frontend_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned LINE_OFFSET_BITS = 4;
  localparam int unsigned CLC_WIDTH        = XLEN - LINE_OFFSET_BITS;
  localparam int unsigned RAS_DEPTH        = 8;
  localparam int unsigned RAS_PTR_W        = $clog2(RAS_DEPTH);
  localparam int unsigned RAS_CNT_W        = RAS_PTR_W + 1;
  localparam logic [XLEN-1:0] RESET_PC     = 32'h0000_0000;

  // Byte address to cache-line number; intra-line offset is dropped.
  function automatic logic [CLC_WIDTH-1:0] line_of(input logic [XLEN-1:0] addr);
    return addr[XLEN-1:LINE_OFFSET_BITS];
  endfunction

endpackage

// File: rtl/c_ras.sv
// Return-address stack: circular buffer whose oldest entry is overwritten on overflow.
module c_ras
  import frontend_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            clear,
  input  logic [XLEN-1:0] din,
  output logic [XLEN-1:0] dout,
  output logic            valid
);

  logic [XLEN-1:0]      mem [RAS_DEPTH];
  logic [RAS_PTR_W-1:0] top;
  logic [RAS_CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      top   <= '0;
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (push && pop) begin
      if (count == '0) count <= RAS_CNT_W'(1);
    end else if (push) begin
      top <= top + RAS_PTR_W'(1);
      if (count != RAS_CNT_W'(RAS_DEPTH)) count <= count + RAS_CNT_W'(1);
    end else if (pop && (count != '0)) begin
      top   <= top - RAS_PTR_W'(1);
      count <= count - RAS_CNT_W'(1);
    end
  end

  // Storage carries no reset; reads are gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (rst && !clear) begin
      if (push && pop)   mem[top] <= din;
      else if (push)     mem[top + RAS_PTR_W'(1)] <= din;
    end
  end

  assign valid = (count != '0);
  assign dout  = valid ? mem[top] : '0;

endmodule

// File: rtl/c_top.sv
// Frontend C1: fetch line pointer, even/odd cache-line counters and the RAS.
module c_top
  import frontend_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_in,
  input  logic                 resteer,
  input  logic [XLEN-1:0]      resteer_target_D1,
  input  logic                 resteer_taken_D1,
  input  logic [XLEN-1:0]      resteer_target_BR,
  input  logic                 resteer_taken_BR,
  input  logic [XLEN-1:0]      resteer_target_ROB,
  input  logic                 resteer_taken_ROB,
  input  logic                 ras_push,
  input  logic                 ras_pop,
  input  logic [XLEN-1:0]      ras_ret_addr,
  input  logic                 ras_valid_in,
  output logic [CLC_WIDTH-1:0] clc_even,
  output logic [CLC_WIDTH-1:0] clc_odd,
  output logic [XLEN-1:0]      ras_data_out,
  output logic                 ras_valid_out
);

  logic [CLC_WIDTH-1:0] line_q;
  logic [CLC_WIDTH-1:0] line_p1;

  // Redirects outrank stall; ROB is the oldest and wins over BR and D1.
  always_ff @(posedge clk) begin
    if (!rst)                   line_q <= line_of(RESET_PC);
    else if (resteer_taken_ROB) line_q <= line_of(resteer_target_ROB);
    else if (resteer_taken_BR)  line_q <= line_of(resteer_target_BR);
    else if (resteer_taken_D1)  line_q <= line_of(resteer_target_D1);
    else if (!stall_in)         line_q <= line_q + CLC_WIDTH'(2);
  end

  assign line_p1  = line_q + CLC_WIDTH'(1);
  assign clc_even = line_q[0] ? line_p1 : line_q;
  assign clc_odd  = line_q[0] ? line_q  : line_p1;

  c_ras u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (ras_push & ras_valid_in),
    .pop   (ras_pop),
    .clear (resteer_taken_ROB),
    .din   (ras_ret_addr),
    .dout  (ras_data_out),
    .valid (ras_valid_out)
  );

  // Flush marker and intra-line offsets are consumed further down the pipe.
  logic unused_ok;
  assign unused_ok = ^{resteer,
                       resteer_target_D1[LINE_OFFSET_BITS-1:0],
                       resteer_target_BR[LINE_OFFSET_BITS-1:0],
                       resteer_target_ROB[LINE_OFFSET_BITS-1:0]};

endmodule

// File: tb/tb_c_top.sv
// Bench for c_top: directed scenarios plus random traffic against a queue-based model.
module tb_c_top;
  import frontend_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            stall_in;
  logic            resteer;
  logic [XLEN-1:0] resteer_target_D1, resteer_target_BR, resteer_target_ROB;
  logic            resteer_taken_D1, resteer_taken_BR, resteer_taken_ROB;
  logic            ras_push, ras_pop, ras_valid_in;
  logic [XLEN-1:0] ras_ret_addr;
  logic [CLC_WIDTH-1:0] clc_even, clc_odd;
  logic [XLEN-1:0] ras_data_out;
  logic            ras_valid_out;

  int total = 0;
  int bad   = 0;

  logic [CLC_WIDTH-1:0] m_line;
  logic [XLEN-1:0]      m_ras [$];

  always #5 clk = ~clk;

  c_top dut (
    .clk                (clk),
    .rst                (rst),
    .stall_in           (stall_in),
    .resteer            (resteer),
    .resteer_target_D1  (resteer_target_D1),
    .resteer_taken_D1   (resteer_taken_D1),
    .resteer_target_BR  (resteer_target_BR),
    .resteer_taken_BR   (resteer_taken_BR),
    .resteer_target_ROB (resteer_target_ROB),
    .resteer_taken_ROB  (resteer_taken_ROB),
    .ras_push           (ras_push),
    .ras_pop            (ras_pop),
    .ras_ret_addr       (ras_ret_addr),
    .ras_valid_in       (ras_valid_in),
    .clc_even           (clc_even),
    .clc_odd            (clc_odd),
    .ras_data_out       (ras_data_out),
    .ras_valid_out      (ras_valid_out)
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: line arithmetic from byte addresses, RAS as a bounded queue.
  task automatic model_update();
    logic do_push;
    if (!rst) begin
      m_line = CLC_WIDTH'(RESET_PC / 16);
      m_ras.delete();
    end else begin
      if (resteer_taken_ROB)     m_line = CLC_WIDTH'(resteer_target_ROB / 16);
      else if (resteer_taken_BR) m_line = CLC_WIDTH'(resteer_target_BR / 16);
      else if (resteer_taken_D1) m_line = CLC_WIDTH'(resteer_target_D1 / 16);
      else if (!stall_in)        m_line = m_line + CLC_WIDTH'(2);
      do_push = ras_push && ras_valid_in;
      if (resteer_taken_ROB) m_ras.delete();
      else if (do_push && ras_pop) begin
        if (m_ras.size() == 0) m_ras.push_back(ras_ret_addr);
        else m_ras[m_ras.size()-1] = ras_ret_addr;
      end else if (do_push) begin
        m_ras.push_back(ras_ret_addr);
        if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
      end else if (ras_pop && m_ras.size() != 0) begin
        void'(m_ras.pop_back());
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [CLC_WIDTH-1:0] e_even, e_odd;
    logic [XLEN-1:0]      e_top;
    e_even    = m_line + CLC_WIDTH'(1);
    e_even[0] = 1'b0;
    e_odd     = m_line | CLC_WIDTH'(1);
    e_top     = (m_ras.size() != 0) ? m_ras[m_ras.size()-1] : '0;
    chk({tag, ".even"},  XLEN'(clc_even), XLEN'(e_even));
    chk({tag, ".odd"},   XLEN'(clc_odd),  XLEN'(e_odd));
    chk({tag, ".ras"},   ras_data_out,    e_top);
    chk({tag, ".rasv"},  XLEN'(ras_valid_out), XLEN'(m_ras.size() != 0));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_update();
    #1;
    check_model(tag);
  endtask

  task automatic idle();
    rst = 1'b1; stall_in = 1'b0; resteer = 1'b0;
    resteer_taken_D1 = 1'b0; resteer_taken_BR = 1'b0; resteer_taken_ROB = 1'b0;
    resteer_target_D1 = '0; resteer_target_BR = '0; resteer_target_ROB = '0;
    ras_push = 1'b0; ras_pop = 1'b0; ras_valid_in = 1'b0; ras_ret_addr = '0;
  endtask

  task automatic chk_clc(input string tag, input logic [XLEN-1:0] e, input logic [XLEN-1:0] o);
    chk({tag, ".even"}, XLEN'(clc_even), e);
    chk({tag, ".odd"},  XLEN'(clc_odd),  o);
  endtask

  task automatic push_val(input logic [XLEN-1:0] v);
    ras_push = 1'b1; ras_valid_in = 1'b1; ras_pop = 1'b0; ras_ret_addr = v;
  endtask

  initial begin
    idle();
    m_line = '0;

    rst = 1'b0; step("reset");
    chk_clc("reset", 32'h0, 32'h1);
    chk("reset.rasv", XLEN'(ras_valid_out), 32'h0);
    chk("reset.ras", ras_data_out, 32'h0);
    rst = 1'b1;
    step("run1"); chk_clc("run1", 32'h2, 32'h3);
    step("run2"); chk_clc("run2", 32'h4, 32'h5);

    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin step("stall"); chk_clc("stall", 32'h4, 32'h5); end
    stall_in = 1'b0;
    step("resume"); chk_clc("resume", 32'h6, 32'h7);

    resteer = 1'b1;
    resteer_taken_ROB = 1'b1; resteer_target_ROB = 32'h1000;
    resteer_taken_BR  = 1'b1; resteer_target_BR  = 32'h2000;
    resteer_taken_D1  = 1'b1; resteer_target_D1  = 32'h3000;
    step("prio"); chk_clc("prio", 32'h100, 32'h101);
    idle();
    resteer_taken_BR = 1'b1; resteer_target_BR = 32'h2014;
    step("br_odd"); chk_clc("br_odd", 32'h202, 32'h201);
    resteer_target_BR = 32'h40; stall_in = 1'b1;
    step("br_stall"); chk_clc("br_stall", 32'h4, 32'h5);
    idle();
    resteer_taken_D1 = 1'b1; resteer_target_D1 = 32'hFFFF_FFF0;
    step("wrap"); chk_clc("wrap", 32'h0, 32'h0FFF_FFFF);
    idle();
    step("wrap1"); chk_clc("wrap1", 32'h2, 32'h1);

    push_val(32'hA); step("pushA");
    push_val(32'hB); step("pushB");
    chk("pushB.ras", ras_data_out, 32'hB);
    chk("pushB.rasv", XLEN'(ras_valid_out), 32'h1);
    push_val(32'hC); ras_pop = 1'b1; step("pushpopC");
    chk("pushpopC.ras", ras_data_out, 32'hC);
    idle(); ras_pop = 1'b1;
    step("pop1"); step("pop2");
    chk("empty.ras", ras_data_out, 32'h0);
    chk("empty.rasv", XLEN'(ras_valid_out), 32'h0);
    step("pop_empty");

    for (int i = 1; i <= 9; i++) begin push_val(32'h100 + XLEN'(i)); step("fill"); end
    idle(); ras_pop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ovf.top", ras_data_out, 32'h109 - XLEN'(i));
      step("ovf.pop");
    end
    chk("ovf.rasv", XLEN'(ras_valid_out), 32'h0);

    push_val(32'hDEAD); step("pre_clr");
    push_val(32'hBEEF); resteer_taken_ROB = 1'b1; resteer_target_ROB = 32'h500;
    step("rob_clr");
    chk("rob_clr.rasv", XLEN'(ras_valid_out), 32'h0);
    chk_clc("rob_clr", 32'h50, 32'h51);
    idle();

    for (int i = 0; i < 600; i++) begin
      rst               = ($urandom_range(0, 49) != 0);
      stall_in          = ($urandom_range(0, 3) == 0);
      resteer           = $urandom_range(0, 1) == 1;
      resteer_taken_ROB = ($urandom_range(0, 19) == 0);
      resteer_taken_BR  = ($urandom_range(0, 9) == 0);
      resteer_taken_D1  = ($urandom_range(0, 7) == 0);
      resteer_target_ROB = $urandom;
      resteer_target_BR  = $urandom;
      resteer_target_D1  = $urandom;
      ras_push     = $urandom_range(0, 1) == 1;
      ras_valid_in = ($urandom_range(0, 4) != 0);
      ras_pop      = ($urandom_range(0, 2) == 0);
      ras_ret_addr = $urandom;
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
